// File: rtl/psr_controller_if.sv
// Bundle of decoder/ALU/branch-unit signals around the processor status register.
// The master side drives flag updates and stack commands; the slave side owns the flags.
interface psr_controller_if #(
    parameter int DEPTH_W = 3
);
    logic [4:0]         alu_flags;
    logic [4:0]         alu_flag_we;
    logic               psr_we;
    logic [4:0]         psr_wdata;
    logic               save;
    logic               restore;
    logic               clear_err;
    logic [3:0]         cond_code;
    logic [4:0]         flags_out;
    logic               cond_true;
    logic [DEPTH_W-1:0] stack_depth;
    logic               overflow_err;
    logic               underflow_err;

    modport master (
        output alu_flags, alu_flag_we, psr_we, psr_wdata,
        output save, restore, clear_err, cond_code,
        input  flags_out, cond_true, stack_depth, overflow_err, underflow_err
    );

    modport slave (
        input  alu_flags, alu_flag_we, psr_we, psr_wdata,
        input  save, restore, clear_err, cond_code,
        output flags_out, cond_true, stack_depth, overflow_err, underflow_err
    );
endinterface

// File: rtl/psr_controller.sv
// Processor status flags {C,Z,L,F,N} with prioritised updates, an interrupt
// context stack (push/pop/swap) with sticky error bits, and condition evaluation.
module psr_controller #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    psr_controller_if.slave  bus
);
    localparam int                 IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_V = DEPTH_W'(DEPTH);

    // Condition code table evaluated against {C,Z,L,F,N}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [4:0] f);
        logic c, z, l, fl, n, r;
        c  = f[4];
        z  = f[3];
        l  = f[2];
        fl = f[1];
        n  = f[0];
        case (cc)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = l;
            4'b0101: r = ~l;
            4'b0110: r = n;
            4'b0111: r = ~n;
            4'b1000: r = fl;
            4'b1001: r = ~fl;
            4'b1010: r = ~l & ~z;
            4'b1011: r = l | z;
            4'b1100: r = ~n & ~z;
            4'b1101: r = n | z;
            4'b1110: r = 1'b1;
            4'b1111: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [4:0]         flags_q, flags_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic [4:0]         stack_q [DEPTH];

    logic               empty_s, full_s, pop_ok_s;
    logic               push_s, pop_s, swap_s;
    logic               ovf_set_s, udf_set_s;
    logic               wr_en_s;
    logic [IDX_W-1:0]   top_idx_s, wr_idx_s;
    logic [4:0]         top_s;

    // Stack command decode, flag next-state priority and error bookkeeping.
    always_comb begin
        empty_s   = (depth_q == {DEPTH_W{1'b0}});
        full_s    = (depth_q >= DEPTH_V);
        top_idx_s = IDX_W'(depth_q - DEPTH_W'(1));
        top_s     = stack_q[top_idx_s];
        pop_ok_s  = bus.restore & ~empty_s;

        // Save+restore on an empty stack degrades to a plain save.
        swap_s    = bus.save & pop_ok_s;
        push_s    = bus.save & ~pop_ok_s & ~full_s;
        pop_s     = pop_ok_s & ~bus.save;
        ovf_set_s = bus.save & ~pop_ok_s & full_s;
        udf_set_s = bus.restore & empty_s;

        if (pop_ok_s) begin
            flags_d = top_s;
        end else if (bus.psr_we) begin
            flags_d = bus.psr_wdata;
        end else begin
            flags_d = (flags_q & ~bus.alu_flag_we) | (bus.alu_flags & bus.alu_flag_we);
        end

        if (push_s) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop_s) begin
            depth_d = depth_q - DEPTH_W'(1);
        end else begin
            depth_d = depth_q;
        end

        wr_en_s = push_s | swap_s;
        if (push_s) begin
            wr_idx_s = IDX_W'(depth_q);
        end else begin
            wr_idx_s = top_idx_s;
        end

        ovf_d = ovf_set_s | (ovf_q & ~bus.clear_err);
        udf_d = udf_set_s | (udf_q & ~bus.clear_err);
    end

    // Flag, depth and sticky error registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 5'b00000;
            depth_q <= {DEPTH_W{1'b0}};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Context storage; a push or swap always stores the pre-update flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= 5'b00000;
            end
        end else if (wr_en_s) begin
            stack_q[wr_idx_s] <= flags_q;
        end else begin
            stack_q[wr_idx_s] <= stack_q[wr_idx_s];
        end
    end

    assign bus.flags_out     = flags_q;
    assign bus.stack_depth   = depth_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
    assign bus.cond_true     = cond_eval(bus.cond_code, flags_q);
endmodule

// File: tb/tb_psr_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based flag/stack model.
module tb_psr_controller;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    logic [4:0] m_flags = 5'b00000;
    logic [4:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    always #5 clk = ~clk;

    psr_controller_if #(.DEPTH_W(3)) bus ();

    psr_controller #(.DEPTH(DEPTH), .DEPTH_W(3)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs: odd codes invert the even one.
    function automatic logic cond_model(input logic [3:0] cc, input logic [4:0] f);
        logic base;
        case (cc[3:1])
            3'd0: base = f[3];
            3'd1: base = f[4];
            3'd2: base = f[2];
            3'd3: base = f[0];
            3'd4: base = f[1];
            3'd5: base = ~(f[2] | f[3]);
            3'd6: base = ~(f[0] | f[3]);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic model_update();
        logic [4:0] nf;
        int  sz;
        bit  pop_ok, ovf_set, udf_set;
        sz      = m_q.size();
        pop_ok  = bus.restore && (sz > 0);
        ovf_set = 1'b0;
        udf_set = bus.restore && (sz == 0);
        if (pop_ok)           nf = m_q[sz-1];
        else if (bus.psr_we)  nf = bus.psr_wdata;
        else                  nf = (m_flags & ~bus.alu_flag_we) | (bus.alu_flags & bus.alu_flag_we);
        if (bus.save && pop_ok) m_q[sz-1] = m_flags;
        else if (bus.save) begin
            if (sz < DEPTH) m_q.push_back(m_flags);
            else            ovf_set = 1'b1;
        end else if (pop_ok) void'(m_q.pop_back());
        m_ovf   = ovf_set | (m_ovf & ~bus.clear_err);
        m_udf   = udf_set | (m_udf & ~bus.clear_err);
        m_flags = nf;
    endtask

    task automatic idle();
        bus.alu_flags   = 5'b00000;
        bus.alu_flag_we = 5'b00000;
        bus.psr_we      = 1'b0;
        bus.psr_wdata   = 5'b00000;
        bus.save        = 1'b0;
        bus.restore     = 1'b0;
        bus.clear_err   = 1'b0;
    endtask

    // One clock: model follows the inputs sampled at the edge, then inputs return to idle.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        idle();
    endtask

    task automatic psr_save(input logic [4:0] v, input bit s, input bit r);
        bus.psr_we    = 1'b1;
        bus.psr_wdata = v;
        bus.save      = s;
        bus.restore   = r;
        step();
    endtask

    task automatic cmd(input bit s, input bit r, input bit c);
        bus.save      = s;
        bus.restore   = r;
        bus.clear_err = c;
        step();
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("flags", 32'(bus.flags_out), 32'(m_flags));
            chk("depth", 32'(bus.stack_depth), 32'(m_q.size()));
            chk("ovf", 32'(bus.overflow_err), 32'(m_ovf));
            chk("udf", 32'(bus.underflow_err), 32'(m_udf));
            chk("cond", 32'(bus.cond_true), 32'(cond_model(bus.cond_code, m_flags)));
        end
    end

    initial begin
        idle();
        bus.cond_code = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", 32'(bus.flags_out), 32'h0);
        chk("rst_depth", 32'(bus.stack_depth), 32'h0);
        chk("rst_errs", 32'({bus.overflow_err, bus.underflow_err}), 32'h0);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        bus.alu_flags = 5'b11111; bus.alu_flag_we = 5'b01000;
        step();
        chk("alu_z", 32'(bus.flags_out), 32'h08);
        bus.cond_code = 4'b0000; #1;
        chk("eq_lit", 32'(bus.cond_true), 32'h1);
        bus.cond_code = 4'b0001; #1;
        chk("ne_lit", 32'(bus.cond_true), 32'h0);

        bus.alu_flags = 5'b00000; bus.alu_flag_we = 5'b11111;
        psr_save(5'b10101, 1'b0, 1'b0);
        chk("psr_prio", 32'(bus.flags_out), 32'h15);

        psr_save(5'b00010, 1'b1, 1'b0);
        chk("save_flags", 32'(bus.flags_out), 32'h02);
        chk("save_depth", 32'(bus.stack_depth), 32'h1);
        cmd(1'b0, 1'b1, 1'b0);
        chk("rest_flags", 32'(bus.flags_out), 32'h15);
        chk("rest_depth", 32'(bus.stack_depth), 32'h0);

        psr_save(5'd1, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++) psr_save(5'(i), 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.overflow_err), 32'h1);
        chk("ovf_depth", 32'(bus.stack_depth), 32'h4);
        for (int i = 4; i >= 1; i--) begin
            cmd(1'b0, 1'b1, 1'b0);
            chk("lifo", 32'(bus.flags_out), 32'(i));
        end
        cmd(1'b0, 1'b1, 1'b0);
        chk("udf_set", 32'(bus.underflow_err), 32'h1);
        chk("udf_flags", 32'(bus.flags_out), 32'h1);
        cmd(1'b0, 1'b0, 1'b1);
        chk("clr_errs", 32'({bus.overflow_err, bus.underflow_err}), 32'h0);

        psr_save(5'b00001, 1'b0, 1'b0);
        psr_save(5'b11000, 1'b1, 1'b0);
        cmd(1'b1, 1'b1, 1'b0);
        chk("swap_flags", 32'(bus.flags_out), 32'h01);
        chk("swap_depth", 32'(bus.stack_depth), 32'h1);
        cmd(1'b0, 1'b1, 1'b0);
        chk("swap_top", 32'(bus.flags_out), 32'h18);
        cmd(1'b1, 1'b1, 1'b0);
        chk("swap_empty_udf", 32'({bus.stack_depth, bus.underflow_err}), 32'h3);
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b0, 1'b1, 1'b0);

        psr_save(5'b00000, 1'b0, 1'b0);
        bus.cond_code = 4'b1010; #1;
        chk("lo_lit", 32'(bus.cond_true), 32'h1);
        psr_save(5'b00001, 1'b0, 1'b0);
        bus.cond_code = 4'b1100; #1;
        chk("lt_lit", 32'(bus.cond_true), 32'h0);

        chk_en = 1'b0;
        for (int f = 0; f < 32; f++) begin
            psr_save(5'(f), 1'b0, 1'b0);
            for (int cc = 0; cc < 16; cc++) begin
                bus.cond_code = 4'(cc);
                #1;
                chk("sweep", 32'(bus.cond_true), 32'(cond_model(4'(cc), 5'(f))));
            end
        end
        @(posedge clk); #1;
        chk_en = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            bus.alu_flags   = 5'($urandom);
            bus.alu_flag_we = 5'($urandom);
            bus.psr_we      = ($urandom_range(0, 3) == 0);
            bus.psr_wdata   = 5'($urandom);
            bus.save        = ($urandom_range(0, 2) == 0);
            bus.restore     = ($urandom_range(0, 2) == 0);
            bus.clear_err   = ($urandom_range(0, 9) == 0);
            bus.cond_code   = 4'($urandom);
            step();
        end
        cmd(1'b0, 1'b0, 1'b1);

        while (m_q.size() > 0) cmd(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) psr_save(5'(i + 9), 1'b1, 1'b0);
        chk("pre_rst_depth", 32'(bus.stack_depth), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_flags", 32'(bus.flags_out), 32'h0);
        chk("async_depth", 32'(bus.stack_depth), 32'h0);
        m_flags = 5'b00000; m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        #2 rst_n = 1'b1;
        cmd(1'b0, 1'b1, 1'b0);
        chk("post_rst_udf", 32'(bus.underflow_err), 32'h1);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/psr_controller.md
Name: psr_controller

Overview:
- Owns the processor status flags C, Z, L, F, N.
- Merges per-flag ALU updates with explicit status-register writes from the instruction decoder.
- Provides a save/restore stack of flag contexts for interrupt entry and return.
- Evaluates 4-bit branch/jump condition codes against the current flags for the fetch/branch unit.

Parameters:
DEPTH, 4, number of flag contexts the save/restore stack holds (1..8)
DEPTH_W, 3, width of the stack_depth output; must hold the value DEPTH

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
alu_flags  input  5  flag results from the ALU, {C,Z,L,F,N}
alu_flag_we  input  5  per-bit write enable for alu_flags, same bit order
psr_we  input  1  explicit full write of the flags (load-status instruction)
psr_wdata  input  5  data for psr_we, {C,Z,L,F,N}
save  input  1  push current flags_out onto the context stack
restore  input  1  pop the top context into flags_out
clear_err  input  1  clears the sticky error bits
cond_code  input  4  condition to evaluate
flags_out  output  5  registered flags {C,Z,L,F,N}: bit4=C, bit3=Z, bit2=L, bit1=F, bit0=N
cond_true  output  1  cond_code satisfied by the current flags_out
stack_depth  output  DEPTH_W  number of valid stacked contexts
overflow_err  output  1  sticky: a save was attempted while the stack was full
underflow_err  output  1  sticky: a restore was attempted while the stack was empty

Behaviour:
- Reset (asynchronous, reset_n=0): flags_out=0, stack_depth=0, overflow_err=0, underflow_err=0. Stack contents are don't-care.
- A reset asserted mid-operation abandons all pending saves and restores.
- Flag next-state priority, evaluated per cycle: restore (stack non-empty) > psr_we > alu_flag_we.
  - Restore with a non-empty stack: flags_out <= stack top.
  - Otherwise, psr_we=1: flags_out <= psr_wdata.
  - Otherwise: each bit i with alu_flag_we[i]=1 takes alu_flags[i]; bits with enable 0 hold.
- The losing sources in a cycle are discarded, not deferred.
- Save, stack not full and restore=0: stack[stack_depth] <= flags_out (pre-update value), stack_depth +1. The flag update in the same cycle still applies.
- Save, stack full: no push, stack_depth unchanged, overflow_err <= 1. The flag update still applies.
- Restore, stack empty: flags_out is updated by psr_we/ALU as if restore were 0, underflow_err <= 1.
- Save and restore together, depth>0 (swap): flags_out <= top, top <= old flags_out, stack_depth unchanged.
- Save and restore together, depth=0: behaves as a plain save, and underflow_err <= 1.
- clear_err=1 clears both error bits. If a new error occurs in the same cycle, the set wins.
- Latency: every update is visible on flags_out one cycle after the input. The stack is LIFO with no wrap-around.
- cond_true is combinational from the registered flags_out and cond_code:
  0000 EQ Z=1; 0001 NE Z=0; 0010 CS C=1; 0011 CC C=0; 0100 HI L=1; 0101 LS L=0; 0110 GT N=1; 0111 LE N=0;
  1000 FS F=1; 1001 FC F=0; 1010 LO L=0&Z=0; 1011 HS L=1|Z=1; 1100 LT N=0&Z=0; 1101 GE N=1|Z=1; 1110 UC always 1; 1111 never 0.

Test Plan:
- Reset, then alu_flags=5'b11111 with alu_flag_we=5'b01000 -> next cycle flags_out=5'b01000; cond_code=0000 gives cond_true=1, cond_code=0001 gives 0.
- Same cycle psr_we=1, psr_wdata=5'b10101, alu_flag_we=5'b11111, alu_flags=0 -> flags_out=5'b10101.
- From flags_out=5'b10101: save with psr_wdata=5'b00010 (psr_we=1) -> flags_out=5'b00010, stack_depth=1. Then restore -> flags_out=5'b10101, stack_depth=0.
- Four saves of 1, 2, 3, 4 (DEPTH=4), then a fifth save -> overflow_err=1, depth stays 4. Four restores return 4, 3, 2, 1. A fifth restore -> underflow_err=1, flags unchanged. clear_err -> both errors 0.
- Depth=1 holding 5'b00001, flags_out=5'b11000, save+restore together -> flags_out=5'b00001, top=5'b11000, depth=1.
- Sweep all 16 cond_codes across all 32 flag values -> cond_true matches the table. Assert reset_n mid-sequence with depth=3 -> flags_out=0 and depth=0 immediately, without waiting for a clock edge.
